// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, a single-outstanding imem handshake,
// a one-entry hold buffer, the IF_ID register and stall/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IF_en,
  input  logic                 IF_ID_en,
  input  logic                 is_nop_IF_ID,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          pc_IF_ID,
  output logic [31:0]          inst_IF_ID,
  output logic                 valid_IF_ID,
  output logic                 fetch_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_cycles
);

  // state  | meaning
  // S_REQ  | idle, may issue a fetch for pc
  // S_WAIT | one request outstanding, response pending
  // S_HOLD | response parked in the hold buffer, waiting for IF_ID
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [31:0]          NOP     = 32'h0000_0013;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        drop;
  logic        resp_ok;
  logic        id_take;
  logic        unused_redirect_lsbs;

  assign imem_addr  = pc;
  assign imem_req   = (state == S_REQ) & IF_en & ~redirect_valid & ~rst;
  assign fetch_busy = (state != S_REQ);
  assign resp_ok    = (state == S_WAIT) & imem_rvalid & ~drop;
  assign id_take    = IF_ID_en & ~is_nop_IF_ID;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      pc_inflight  <= 32'h0;
      hold_pc      <= 32'h0;
      hold_inst    <= NOP;
      drop         <= 1'b0;
      pc_IF_ID     <= 32'h0;
      inst_IF_ID   <= NOP;
      valid_IF_ID  <= 1'b0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!IF_en && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_ONE;
      if ((is_nop_IF_ID || redirect_valid) && !(&flush_cycles))
        flush_cycles <= flush_cycles + CNT_ONE;

      if (redirect_valid) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        pc_IF_ID    <= 32'h0;
        inst_IF_ID  <= NOP;
        valid_IF_ID <= 1'b0;
        case (state)
          S_WAIT: begin
            // a response in the same cycle is simply discarded; otherwise
            // remember to discard the one still on its way
            if (imem_rvalid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end
          S_HOLD:  state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end else begin
        if (is_nop_IF_ID) begin
          pc_IF_ID    <= 32'h0;
          inst_IF_ID  <= NOP;
          valid_IF_ID <= 1'b0;
        end else if (IF_ID_en) begin
          if (state == S_HOLD) begin
            pc_IF_ID    <= hold_pc;
            inst_IF_ID  <= hold_inst;
            valid_IF_ID <= 1'b1;
          end else if (resp_ok) begin
            pc_IF_ID    <= pc_inflight;
            inst_IF_ID  <= imem_rdata;
            valid_IF_ID <= 1'b1;
          end else begin
            pc_IF_ID    <= 32'h0;
            inst_IF_ID  <= NOP;
            valid_IF_ID <= 1'b0;
          end
        end

        case (state)
          S_REQ: begin
            if (imem_req && imem_ready) begin
              pc_inflight <= pc;
              pc          <= pc + 32'd4;
              state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_REQ;
              end else if (id_take) begin
                state <= S_REQ;
              end else begin
                hold_pc   <= pc_inflight;
                hold_inst <= imem_rdata;
                state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (id_take)
              state <= S_REQ;
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based fetch model is checked against
// the DUT every cycle, plus literal expectations at key points of each scenario.
module tb_fetch_stage;

  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          IF_en = 1'b0, IF_ID_en = 1'b0, is_nop_IF_ID = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   pc_IF_ID, inst_IF_ID;
  logic          valid_IF_ID, fetch_busy;
  logic [CW-1:0] stall_cycles, flush_cycles;

  fetch_stage #(.RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .IF_en(IF_en), .IF_ID_en(IF_ID_en),
    .is_nop_IF_ID(is_nop_IF_ID), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_IF_ID(pc_IF_ID), .inst_IF_ID(inst_IF_ID), .valid_IF_ID(valid_IF_ID),
    .fetch_busy(fetch_busy), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory responder: answers an accepted request mem_lat cycles later
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // model: outstanding flag, discard flag, hold queue, counters as integers
  bit          m_init = 0;
  logic [31:0] m_pc;
  bit          m_out, m_disc;
  logic [31:0] m_out_pc;
  logic [31:0] hq_pc[$];
  logic [31:0] hq_inst[$];
  logic [31:0] m_id_pc, m_id_inst;
  bit          m_id_v;
  int          m_stall, m_flush;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return m_out || (hq_pc.size() != 0);
  endfunction

  task automatic m_bubble();
    m_id_pc = 32'h0; m_id_inst = NOP; m_id_v = 0;
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_out = 0; m_disc = 0; m_out_pc = 32'h0;
    hq_pc.delete(); hq_inst.delete();
    m_bubble();
    m_stall = 0; m_flush = 0;
  endtask

  task automatic compare_all();
    bit exp_req;
    exp_req = !rst && !m_busy() && IF_en && !redirect_valid;
    chk("imem_req",     {31'h0, imem_req},    {31'h0, exp_req});
    chk("imem_addr",    imem_addr,            m_pc);
    chk("pc_IF_ID",     pc_IF_ID,             m_id_pc);
    chk("inst_IF_ID",   inst_IF_ID,           m_id_inst);
    chk("valid_IF_ID",  {31'h0, valid_IF_ID}, {31'h0, m_id_v});
    chk("fetch_busy",   {31'h0, fetch_busy},  {31'h0, m_busy()});
    chk("stall_cycles", 32'(stall_cycles),    32'(m_stall));
    chk("flush_cycles", 32'(flush_cycles),    32'(m_flush));
  endtask

  task automatic model_step();
    bit fire, arrived, good;
    fire = !rst && !m_busy() && IF_en && !redirect_valid && imem_ready;
    if (rst) begin
      m_reset();
      return;
    end
    if (!IF_en && m_stall < (1 << CW) - 1) m_stall++;
    if ((is_nop_IF_ID || redirect_valid) && m_flush < (1 << CW) - 1) m_flush++;
    arrived = m_out && imem_rvalid;
    good    = arrived && !m_disc;
    if (arrived) begin m_out = 0; m_disc = 0; end
    if (redirect_valid) begin
      hq_pc.delete(); hq_inst.delete();
      if (m_out) m_disc = 1;
      m_pc = {redirect_pc[31:2], 2'b00};
      m_bubble();
    end else begin
      if (is_nop_IF_ID) begin
        m_bubble();
        if (good) begin hq_pc.push_back(m_out_pc); hq_inst.push_back(imem_rdata); end
      end else if (IF_ID_en) begin
        if (hq_pc.size() != 0) begin
          m_id_pc = hq_pc.pop_front(); m_id_inst = hq_inst.pop_front(); m_id_v = 1;
        end else if (good) begin
          m_id_pc = m_out_pc; m_id_inst = imem_rdata; m_id_v = 1;
        end else begin
          m_bubble();
        end
      end else if (good) begin
        hq_pc.push_back(m_out_pc); hq_inst.push_back(imem_rdata);
      end
      if (fire) begin
        m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit iden, input bit nop,
                     input bit rdv, input logic [31:0] rpc, input bit rdy);
    rst = r; IF_en = en; IF_ID_en = iden; is_nop_IF_ID = nop;
    redirect_valid = rdv; redirect_pc = rpc; imem_ready = rdy;
    imem_rvalid = (mem_cnt == 1);
    imem_rdata  = imem_rvalid ? tag(mem_addr) : 32'hDEAD_BEEF;
    #1;
    if (m_init) compare_all();
    model_step();
    if (r) m_init = 1;
    if (mem_cnt != 0) mem_cnt--;
    if (imem_req && imem_ready) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
    @(negedge clk);
  endtask

  task automatic run();
    cyc(0, 1, 1, 0, 0, 32'h0, 1);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 32'h0, 1);
    chk("rst_valid", {31'h0, valid_IF_ID}, 32'h0);
    chk("rst_inst",  inst_IF_ID, NOP);

    // steady fetch
    run(); run();
    chk("s1_pc0",   pc_IF_ID, 32'h0);
    chk("s1_inst0", inst_IF_ID, 32'hA5A5_0000);
    run(); run();
    chk("s1_pc4",   pc_IF_ID, 32'h4);
    chk("s1_flush", 32'(flush_cycles), 32'h0);

    // stall with a response parked in the hold buffer
    cyc(0, 1, 0, 0, 0, 32'h0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 32'h0, 1);
    chk("s2_hold_pc", pc_IF_ID, 32'h4);
    chk("s2_addr",    imem_addr, 32'hC);
    chk("s2_stall",   32'(stall_cycles), 32'd3);
    chk("s2_busy",    {31'h0, fetch_busy}, 32'h1);
    run();
    chk("s2_pc8",     pc_IF_ID, 32'h8);
    chk("s2_v8",      {31'h0, valid_IF_ID}, 32'h1);

    // bubble while the 0x10 response arrives
    run(); run();
    chk("s3_pcC", pc_IF_ID, 32'hC);
    run();
    cyc(0, 1, 1, 1, 0, 32'h0, 1);
    chk("s3_bubble", {31'h0, valid_IF_ID}, 32'h0);
    chk("s3_busy",   {31'h0, fetch_busy}, 32'h1);
    chk("s3_flush",  32'(flush_cycles), 32'd1);
    run();
    chk("s3_pc10",   pc_IF_ID, 32'h10);
    chk("s3_inst10", inst_IF_ID, 32'hA5A5_0010);

    // redirect while 0x14 is outstanding
    mem_lat = 2;
    run();
    cyc(0, 1, 1, 0, 1, 32'h103, 1);
    chk("s4_addr",  imem_addr, 32'h100);
    chk("s4_flush", 32'(flush_cycles), 32'd2);
    run();
    chk("s4_drop_v", {31'h0, valid_IF_ID}, 32'h0);
    chk("s4_idle",   {31'h0, fetch_busy}, 32'h0);
    mem_lat = 1;
    run();
    // redirect coinciding with the response
    cyc(0, 1, 1, 0, 1, 32'h20, 1);
    chk("s4b_addr",  imem_addr, 32'h20);
    chk("s4b_busy",  {31'h0, fetch_busy}, 32'h0);
    chk("s4b_flush", 32'(flush_cycles), 32'd3);

    // memory not ready for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 0, 32'h0, 0);
      chk("s5_addr", imem_addr, 32'h20);
    end
    mem_lat = 2;
    run();
    chk("s5_pc24", imem_addr, 32'h24);

    // reset in S_WAIT, stale response the next cycle
    cyc(1, 1, 1, 0, 0, 32'h0, 1);
    chk("s6_addr",  imem_addr, 32'h0);
    chk("s6_stall", 32'(stall_cycles), 32'h0);
    chk("s6_flush", 32'(flush_cycles), 32'h0);
    mem_lat = 1;
    run();
    chk("s6_bubble", {31'h0, valid_IF_ID}, 32'h0);
    chk("s6_addr4",  imem_addr, 32'h4);
    run();
    chk("s6_pc0",   pc_IF_ID, 32'h0);
    chk("s6_inst0", inst_IF_ID, 32'hA5A5_0000);

    // redirect empties the hold buffer
    cyc(0, 1, 0, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 0, 0, 32'h0, 1);
    chk("s7_busy", {31'h0, fetch_busy}, 32'h1);
    cyc(0, 1, 1, 0, 1, 32'h42, 1);
    chk("s7_idle", {31'h0, fetch_busy}, 32'h0);
    chk("s7_addr", imem_addr, 32'h40);
    run(); run();
    chk("s7_pc40", pc_IF_ID, 32'h40);

    // counter saturation
    repeat (20) cyc(0, 0, 1, 0, 0, 32'h0, 1);
    chk("sat_stall", 32'(stall_cycles), 32'hF);
    repeat (18) cyc(0, 1, 1, 1, 0, 32'h0, 1);
    chk("sat_flush", 32'(flush_cycles), 32'hF);
    repeat (4) run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage that consumes the hazard unit's stall and flush outputs (IF_en, IF_ID_en, is_nop_IF_ID) and the branch redirect from EXE.
- Owns the PC, a single-outstanding instruction-memory request/response handshake, a one-entry hold buffer, and the IF_ID pipeline register.
- A bubble in IF_ID never loses a correctly fetched instruction. Wrong-path instructions are removed only by redirect.
- Keeps saturating stall and flush cycle counters for performance measurement.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
IF_en  in  1  1 = PC may advance and issue a fetch; 0 = PC frozen, no new request
IF_ID_en  in  1  1 = IF_ID may load; 0 = IF_ID holds its contents
is_nop_IF_ID  in  1  load a bubble into IF_ID this cycle
redirect_valid  in  1  branch/jump resolved taken
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
pc_IF_ID  out  32  PC of instruction in IF_ID
inst_IF_ID  out  32  instruction in IF_ID
valid_IF_ID  out  1  IF_ID holds a real instruction
fetch_busy  out  1  request outstanding or hold buffer full
stall_cycles  out  CNT_WIDTH  cycles with IF_en=0
flush_cycles  out  CNT_WIDTH  cycles with is_nop_IF_ID=1 or redirect_valid=1

Behaviour:
- Reset (rst=1 at edge), all registers:
  - pc=RESET_PC, state=S_REQ, drop=0, hold buffer empty.
  - pc_IF_ID=0, inst_IF_ID=32'h0000_0013 (NOP), valid_IF_ID=0.
  - Both counters 0.
  - Reset overrides every other input and drops any in-flight response.
- NOP is always 32'h0000_0013. Bubble = {pc_IF_ID=0, inst_IF_ID=NOP, valid_IF_ID=0}.
- imem_addr = pc (combinational).
- imem_req = (state==S_REQ) & IF_en & ~redirect_valid & ~rst (combinational).
- imem_req stays asserted until imem_ready. Address is stable while req is held.
- State S_REQ:
  - If imem_req & imem_ready: capture pc_inflight=pc, pc<=pc+4 (wraps modulo 2^32), go to S_WAIT.
  - Otherwise remain in S_REQ.
- State S_WAIT, on imem_rvalid:
  - If drop=1: discard the data, clear drop, go to S_REQ.
  - Else if IF_ID may take it (see IF_ID priority below): load IF_ID={pc_inflight, imem_rdata, 1}, go to S_REQ.
  - Else: store the instruction in the hold buffer, go to S_HOLD.
  - imem_rvalid outside S_WAIT is ignored.
- State S_HOLD:
  - No requests are issued.
  - When IF_ID may take the buffered instruction: load it into IF_ID, go to S_REQ.
- IF_ID update priority each cycle:
  1. rst.
  2. redirect_valid or is_nop_IF_ID: load bubble. A response arriving that cycle goes to the hold buffer (S_HOLD) unless redirect_valid.
  3. IF_ID_en=1 with an instruction available (hold buffer or valid response): load it.
  4. IF_ID_en=1 with nothing available: load bubble.
  5. IF_ID_en=0: hold contents.
- Redirect (redirect_valid=1), takes priority over IF_en:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Hold buffer emptied. S_HOLD goes to S_REQ.
  - In S_WAIT without rvalid: set drop=1.
  - In S_WAIT with rvalid the same cycle: discard the response, go to S_REQ.
  - No request is issued in the redirect cycle.
- IF_en=0: pc is unchanged and no new request starts. An outstanding response still completes into IF_ID or the hold buffer.
- fetch_busy = (state != S_REQ).
- stall_cycles increments every non-reset cycle with IF_en=0.
- flush_cycles increments every non-reset cycle with (is_nop_IF_ID | redirect_valid).
- Both counters saturate at all-ones.

Test Plan:
- Reset then steady fetch, imem_ready=1, 1-cycle rvalid returning addr-tagged data → requests at 0x0, 0x4, 0x8. IF_ID shows pc 0x0/0x4/0x8 in order, valid=1; flush_cycles=0.
- IF_en=0 and IF_ID_en=0 for 3 cycles after a response at pc 0x8 → IF_ID holds 0x4, pc stays 0xC, no imem_req, stall_cycles=3. On release, 0x8 enters IF_ID next, with nothing skipped or duplicated.
- is_nop_IF_ID=1 in the same cycle the response for 0x10 arrives → IF_ID gets a bubble (valid=0), state=S_HOLD. Next cycle with IF_ID_en=1, IF_ID={0x10, data, 1}.
- redirect_valid=1 with redirect_pc=0x103 while a request for 0x14 is in S_WAIT → that response is dropped, next request addr=0x100, IF_ID never shows 0x14, flush_cycles increments by 1.
- imem_ready=0 for 4 cycles → imem_req held high with addr constant at 0x20. Accepted on the 5th cycle; pc becomes 0x24.
- rst asserted mid-S_WAIT, with rvalid arriving the next cycle → response ignored, first request after reset at RESET_PC, IF_ID a bubble, counters 0.
